// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: shared state and mode encodings for the CPU clock-enable controller
package cpu_clk_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_S    = 2'd1,
    BURST_S  = 2'd2,
    WAIT_REL = 2'd3
  } state_t;
  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;
endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: switch/button inputs and clock-enable outputs of the CPU clock controller
interface cpu_clk_ctrl_if;
  import cpu_clk_pkg::*;
  logic [1:0] mode_sw;
  logic       speed_sw;
  logic       halt_req;
  logic       btn_step;
  logic [7:0] burst_len;
  logic       cpu_ce;
  logic       busy;
  state_t     state;
  logic [31:0] ce_count;
  modport master (
    output mode_sw, speed_sw, halt_req, btn_step, burst_len,
    input  cpu_ce, busy, state, ce_count
  );
  modport slave (
    input  mode_sw, speed_sw, halt_req, btn_step, burst_len,
    output cpu_ce, busy, state, ce_count
  );
endinterface

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level debounce and rising-edge press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          settle;
  assign settle = (sync[1] != btn_db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk_100mhz or posedge rst)
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      btn_db <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync   <= {sync[0], btn_raw};
      cnt    <= (sync[1] == btn_db || settle) ? '0 : cnt + 1'b1;
      btn_db <= settle ? sync[1] : btn_db;
      press  <= settle & sync[1];
    end
endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: sequences cpu_ce pulses for halt, single-step, burst and free-run modes
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FAST_LOG2       = 4,
  parameter int SLOW_LOG2       = 24
) (
  input logic           clk_100mhz,
  input logic           rst,
  cpu_clk_ctrl_if.slave bus
);
  localparam logic [SLOW_LOG2-1:0] SLOW_MASK = '1;
  localparam logic [SLOW_LOG2-1:0] FAST_MASK = SLOW_MASK >> (SLOW_LOG2 - FAST_LOG2);
  logic [1:0]           mode_m, mode_s;
  logic                 speed_m, speed_s;
  logic                 btn_db, press;
  logic [SLOW_LOG2-1:0] rate, mask;
  logic                 tick, entry, cpu_ce, ce_n;
  state_t               state, state_n;
  logic [7:0]           remaining, rem_n;
  logic [31:0]          ce_count;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk_100mhz(clk_100mhz),
    .rst(rst),
    .btn_raw(bus.btn_step),
    .btn_db(btn_db),
    .press(press)
  );

  assign mask  = speed_s ? SLOW_MASK : FAST_MASK;
  assign tick  = (rate & mask) == mask;
  assign entry = (state_n == RUN_S && state != RUN_S) || (state_n == BURST_S && state != BURST_S);

  always_comb begin
    state_n = state;
    ce_n    = 1'b0;
    rem_n   = remaining;
    case (state)
      IDLE:
        if (!bus.halt_req) begin
          if (mode_s == MODE_RUN) state_n = RUN_S;
          else if (press && mode_s == MODE_STEP) begin
            ce_n    = 1'b1;
            state_n = WAIT_REL;
          end else if (press && mode_s == MODE_BURST) begin
            rem_n   = bus.burst_len;
            state_n = bus.burst_len != 8'd0 ? BURST_S : WAIT_REL;
          end
        end
      RUN_S:
        if (bus.halt_req || mode_s != MODE_RUN) state_n = IDLE;
        else ce_n = tick;
      BURST_S:
        if (bus.halt_req || mode_s != MODE_BURST) begin
          state_n = IDLE;
          rem_n   = '0;
        end else if (tick) begin
          ce_n    = 1'b1;
          rem_n   = remaining - 8'd1;
          state_n = remaining == 8'd1 ? WAIT_REL : BURST_S;
        end
      WAIT_REL:
        if (!btn_db) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst)
    if (rst) begin
      mode_m    <= '0;
      mode_s    <= '0;
      speed_m   <= 1'b0;
      speed_s   <= 1'b0;
      state     <= IDLE;
      cpu_ce    <= 1'b0;
      remaining <= '0;
      ce_count  <= '0;
      rate      <= '0;
    end else begin
      mode_m    <= bus.mode_sw;
      mode_s    <= mode_m;
      speed_m   <= bus.speed_sw;
      speed_s   <= speed_m;
      state     <= state_n;
      cpu_ce    <= ce_n;
      remaining <= rem_n;
      ce_count  <= ce_count + {31'd0, ce_n};
      rate      <= entry ? '0 : rate + 1'b1;
    end

  assign bus.cpu_ce   = cpu_ce;
  assign bus.busy     = state == RUN_S || state == BURST_S;
  assign bus.state    = state;
  assign bus.ce_count = ce_count;
endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

CPU clock-enable controller for the lab SoC. Sequences the CPU's execution rate from the 100 MHz board clock. Supports four modes selected by switches: halt, single-step on a debounced button press, fixed-length burst, and free run at a fast or slow rate. All outputs are single-clock-domain; the CPU qualifies its registers with `cpu_ce` instead of running on a derived clock.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- `FAST_LOG2`, default 4: run-fast tick period is 2^FAST_LOG2 cycles.
- `SLOW_LOG2`, default 24: run-slow tick period is 2^SLOW_LOG2 cycles.
- `clk_100mhz` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `mode_sw` in 2: raw switch input. 00 HALT, 01 STEP, 10 BURST, 11 RUN.
- `speed_sw` in 1: raw switch input. 1 selects the slow rate, 0 the fast rate. Applies in RUN and BURST.
- `halt_req` in 1: synchronous request from the CPU or debug logic, for example a breakpoint.
- `btn_step` in 1: raw, bouncing push-button.
- `burst_len` in 8: number of pulses per burst. Sampled when a burst starts.
- `cpu_ce` out 1: one-cycle clock-enable pulse.
- `busy` out 1: high in RUN_S and BURST_S.
- `state` out 2: current FSM state, for the LED display.
- `ce_count` out 32: total `cpu_ce` pulses issued. Wraps at 2^32.

## Operation
- Input synchronization:
  - `mode_sw`, `speed_sw`, and `btn_step` each pass through a 2-FF synchronizer.
  - `halt_req` is used directly.
- Debounce:
  - `btn_db` is the debounced button level.
  - `btn_db` takes the synchronized level after that level has differed from `btn_db` for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle where the two agree clears the debounce counter.
  - `press` is a one-cycle pulse on each 0→1 transition of `btn_db`.
- Rate counter:
  - Free-running count that is cleared on every entry to RUN_S or BURST_S.
  - `tick` is asserted when the low L bits of the counter are all ones, where L = SLOW_LOG2 if the synchronized `speed_sw` is 1, else FAST_LOG2.
- FSM states, encoded in 2 bits:
  - IDLE=0: `cpu_ce` is 0. Transitions, evaluated in this priority order:
    1. `halt_req` → stay in IDLE.
    2. mode RUN → RUN_S.
    3. mode STEP and `press` → emit `cpu_ce` this cycle, go to WAIT_REL.
    4. mode BURST and `press` and `burst_len`≠0 → load `remaining`=`burst_len`, go to BURST_S.
    5. mode BURST and `press` and `burst_len`=0 → go to WAIT_REL with no pulse.
  - RUN_S=1:
    - `cpu_ce`=`tick`.
    - If mode≠RUN or `halt_req` → IDLE, and no pulse is emitted in that cycle.
  - BURST_S=2:
    - `cpu_ce`=`tick`; each pulse decrements `remaining`.
    - When the pulse with `remaining`=1 issues → WAIT_REL.
    - `halt_req` or mode≠BURST → IDLE immediately with no pulse, and `remaining` is discarded.
  - WAIT_REL=3:
    - `cpu_ce` is 0.
    - When `btn_db`=0 → IDLE. One press yields exactly one step or one burst.
- HALT mode (00) keeps the FSM in IDLE.
- `ce_count` increments in every cycle where `cpu_ce`=1.
- Simultaneous `tick` and `halt_req`: halt wins and no pulse is emitted.
- Changing `speed_sw` mid-run takes effect at the next all-ones match; the counter is not cleared.

## Timing
- Reset values:
  - state=IDLE.
  - `cpu_ce`=0, `busy`=0, `ce_count`=0.
  - `btn_db`=0, synchronizers=0, `remaining`=0, rate counter=0.
- Reset mid-burst aborts with no further pulses.
- Outputs are registered; `cpu_ce` is a registered one-cycle pulse.
- Switch-to-action latency is 2 synchronizer cycles plus 1 FSM cycle.
- Button latency is 2 + DEBOUNCE_CYCLES cycles to `btn_db`, plus 1 cycle to the `cpu_ce` of a step.
- RUN_S: the first pulse occurs 2^L cycles after RUN_S entry, and pulses repeat every 2^L cycles.
- BURST_S with N = `burst_len`: emits exactly N pulses spaced 2^L cycles apart, with the first pulse 2^L cycles after entry.

## Structure
- Package `cpu_clk_pkg` holds:
  - the state enum (IDLE, RUN_S, BURST_S, WAIT_REL);
  - the mode constants (MODE_HALT, MODE_STEP, MODE_BURST, MODE_RUN).
- Sub-module `btn_debounce` contains the synchronizer, debounce counter, and press-edge detector, and is parameterized by DEBOUNCE_CYCLES. It is reused for the other board buttons.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, FAST_LOG2=2, SLOW_LOG2=4.
- **Step with bounce:** mode=01; `btn_step` toggles 0/1 every cycle for 3 cycles, then holds 1 for 10 cycles, then returns to 0. Expect exactly one `cpu_ce`, `ce_count`=1, and the state passes through WAIT_REL and then IDLE.
- **Run fast:** mode=11, `speed_sw`=0, run for 40 cycles. Expect `cpu_ce` every 4 cycles, the first pulse 4 cycles after RUN_S entry, and `busy`=1.
- **Run, then halt:** in RUN_S, assert `halt_req` on a tick cycle. Expect no pulse in that cycle, state=IDLE on the next cycle, and `ce_count` frozen.
- **Burst:** mode=10, `burst_len`=3, `speed_sw`=1, one press. Expect exactly 3 pulses 16 cycles apart, then WAIT_REL. A press with `burst_len`=0 gives 0 pulses.
- **Burst abort:** with `burst_len`=5, change mode to 00 after 2 pulses. Expect the state to reach IDLE 3 cycles after the switch change, with `ce_count`=2.
- **Reset mid-burst:** pulse `rst` mid-burst. Expect all outputs to take their reset values asynchronously and no pulses after release until the next press.
